// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// memory_responder : four-phase handshake responder over a byte-maskable
//                    synchronous RAM with configurable access latency.
// Revision         : 1.0
// ============================================================================
module memory_responder #(
    parameter int SIZE        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    localparam int SIZE_BYTES               = SIZE / 8,
    localparam int MEMORY_WORD_ADDRESS_SIZE = SIZE - $clog2(SIZE_BYTES)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                memory_enable,
    input  logic                                memory_operation,
    output logic                                memory_ready,
    input  logic [SIZE_BYTES-1:0]               memory_byte_mask,
    input  logic [MEMORY_WORD_ADDRESS_SIZE-1:0] memory_word_address,
    input  logic [SIZE-1:0]                     memory_data_out,
    output logic [SIZE-1:0]                     memory_data_in,
    output logic                                access_fault
);

    localparam int INDEX_SIZE = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                              state;
    state_t                              state_next;
    logic [7:0]                          count;
    logic                                op_q;
    logic [SIZE_BYTES-1:0]               mask_q;
    logic [MEMORY_WORD_ADDRESS_SIZE-1:0] addr_q;
    logic [SIZE-1:0]                     wdata_q;
    logic                                access;
    logic                                in_range;
    logic [INDEX_SIZE-1:0]               index;

    logic [SIZE-1:0] mem [DEPTH_WORDS];

    assign in_range     = 64'(addr_q) < 64'(DEPTH_WORDS);
    assign index        = addr_q[INDEX_SIZE-1:0];
    assign access       = (state == BUSY) && (count == 8'd0);
    assign memory_ready = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (memory_enable)  state_next = BUSY;
            BUSY:    if (count == 8'd0)  state_next = DONE;
            DONE:    if (!memory_enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request is captured once in IDLE; inputs are ignored until the next IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count          <= 8'd0;
            op_q           <= 1'b0;
            mask_q         <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            memory_data_in <= '0;
            access_fault   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memory_enable) begin
                        op_q    <= memory_operation;
                        mask_q  <= memory_byte_mask;
                        addr_q  <= memory_word_address;
                        wdata_q <= memory_data_out;
                        count   <= 8'(LATENCY);
                    end
                end
                BUSY: begin
                    if (count != 8'd0) begin
                        count <= count - 8'd1;
                    end else begin
                        access_fault <= !in_range;
                        if (!op_q) begin
                            memory_data_in <= in_range ? mem[index] : '0;
                        end
                    end
                end
                DONE: begin
                    if (!memory_enable) begin
                        access_fault <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Backing store has no reset so that it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (access && op_q && in_range) begin
            for (int b = 0; b < SIZE_BYTES; b++) begin
                if (mask_q[b]) begin
                    mem[index][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// Scoreboard bench for memory_responder: a LATENCY=2 instance and a LATENCY=0
// instance share request buses but have separate enables.
module tb_memory_responder;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en, en0, op;
    logic [3:0]  mask;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        rdy, rdy0, flt, flt0;
    logic [31:0] rd, rd0;
    logic        rdy_prev = 1'b0;
    logic        rdy0_prev = 1'b0;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    memory_responder #(.SIZE(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clock(clk), .reset(rst), .memory_enable(en), .memory_operation(op),
        .memory_ready(rdy), .memory_byte_mask(mask), .memory_word_address(addr),
        .memory_data_out(wdata), .memory_data_in(rd), .access_fault(flt)
    );

    memory_responder #(.SIZE(32), .DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clock(clk), .reset(rst), .memory_enable(en0), .memory_operation(op),
        .memory_ready(rdy0), .memory_byte_mask(mask), .memory_word_address(addr),
        .memory_data_out(wdata), .memory_data_in(rd0), .access_fault(flt0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising ready edge consumes one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (rdy && !rdy_prev) begin
            if (q.size() == 0) chk("unexpected ready", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("data_in", rd, e.data);
                chk("access_fault", {31'd0, flt}, {31'd0, e.fault});
            end
        end
        if (rdy0 && !rdy0_prev) begin
            if (q0.size() == 0) chk("unexpected ready lat0", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("data_in lat0", rd0, e.data);
                chk("access_fault lat0", {31'd0, flt0}, {31'd0, e.fault});
            end
        end
        rdy_prev  = rdy;
        rdy0_prev = rdy0;
    end

    task automatic access(input bit which, input bit wr, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          input logic [31:0] ed, input bit ef, input int hold);
        int          edges;
        int          lat;
        logic [31:0] held;
        exp_t        e;
        lat     = which ? 0 : 2;
        e.data  = ed;
        e.fault = ef;
        @(negedge clk);
        op = wr; addr = a; wdata = d; mask = m;
        if (which) begin en0 = 1'b1; q0.push_back(e); end
        else       begin en  = 1'b1; q.push_back(e);  end
        @(posedge clk);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!(which ? rdy0 : rdy) && edges < 40);
        chk("ready latency", edges, lat + 1);
        held = which ? rd0 : rd;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("ready held", {31'd0, which ? rdy0 : rdy}, 32'd1);
            chk("data held", which ? rd0 : rd, held);
        end
        @(negedge clk);
        en = 1'b0; en0 = 1'b0;
        @(posedge clk); #1;
        chk("ready released", {31'd0, which ? rdy0 : rdy}, 32'd0);
        chk("fault cleared", {31'd0, which ? flt0 : flt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        en = 1'b0; en0 = 1'b0; op = 1'b0; mask = 4'h0; addr = '0; wdata = '0;
        #2 rst = 1'b1;
        #1;
        chk("reset ready", {31'd0, rdy}, 32'd0);
        chk("reset data_in", rd, 32'd0);
        chk("reset fault", {31'd0, flt}, 32'd0);
        chk("reset ready lat0", {31'd0, rdy0}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //     which wr  addr   wdata         mask   exp_data      fault hold
        access(0,    1,  30'd7,    32'h0000_0000, 4'hF, 32'h0000_0000, 0, 0);
        access(0,    1,  30'd5,    32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 0, 0);
        access(0,    0,  30'd5,    32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 0, 0);
        access(0,    1,  30'd5,    32'h1122_3344, 4'h5, 32'hDEAD_BEEF, 0, 0);
        access(0,    0,  30'd5,    32'h0000_0000, 4'hF, 32'hDE22_BE44, 0, 0);
        access(0,    1,  30'd5,    32'hFFFF_FFFF, 4'h0, 32'hDE22_BE44, 0, 0);
        access(0,    0,  30'd5,    32'h0000_0000, 4'h0, 32'hDE22_BE44, 0, 10);
        access(0,    1,  30'd976,  32'h1234_5678, 4'hF, 32'hDE22_BE44, 0, 0);
        access(0,    0,  30'd1024, 32'h0000_0000, 4'hF, 32'h0000_0000, 1, 0);
        access(0,    1,  30'd2000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1, 0);
        access(0,    0,  30'd976,  32'h0000_0000, 4'hF, 32'h1234_5678, 0, 0);

        // Abandon a write to address 7 while the responder is in BUSY.
        @(negedge clk);
        op = 1'b1; addr = 30'd7; wdata = 32'hAAAA_AAAA; mask = 4'hF; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("busy reset ready", {31'd0, rdy}, 32'd0);
        chk("busy reset data_in", rd, 32'd0);
        chk("busy reset fault", {31'd0, flt}, 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(0,    0,  30'd7,    32'h0000_0000, 4'hF, 32'h0000_0000, 0, 0);

        access(1,    1,  30'd0,    32'h0101_0101, 4'hF, 32'h0000_0000, 0, 0);
        access(1,    1,  30'd1,    32'h0202_0202, 4'hF, 32'h0000_0000, 0, 0);
        access(1,    0,  30'd0,    32'h0000_0000, 4'hF, 32'h0101_0101, 0, 0);
        access(1,    0,  30'd1,    32'h0000_0000, 4'hF, 32'h0202_0202, 0, 0);

        repeat (2) @(negedge clk);
        chk("pending responses", q.size(), 32'd0);
        chk("pending responses lat0", q0.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
